// File: rtl/cjb_logic_unit_arbiter_v_pkg.sv
//==============================================================================
// cjb_logic_unit_arbiter_v_pkg : shared state/function encodings and flag helper
// Revision: 1.0
//==============================================================================
`default_nettype none

package cjb_logic_unit_arbiter_v_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [1:0] FS_XOR   = 2'b00;
  localparam logic [1:0] FS_AND   = 2'b01;
  localparam logic [1:0] FS_OR    = 2'b10;
  localparam logic [1:0] FS_PASSX = 2'b11;

  // Logic ops never carry or overflow, so only N and Z are live
  function automatic logic [3:0] cnvz_of(input logic [7:0] r);
    return {1'b0, r[7], 1'b0, (r == 8'h00)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cjb_8bit_logic_unit_v.sv
//==============================================================================
// cjb_8bit_logic_unit_v : combinational 8-bit XOR/AND/OR/pass-X unit
// Revision: 1.0
//==============================================================================
`default_nettype none

module cjb_8bit_logic_unit_v
  import cjb_logic_unit_arbiter_v_pkg::*;
(
  input  logic [1:0] func_sel,
  input  logic [7:0] operand_x,
  input  logic [7:0] operand_y,
  input  logic [1:0] const_k,
  output logic [7:0] result
);

  // Const_K is reserved on this unit; the arbiter ties it off
  logic unused_const_k;
  assign unused_const_k = ^const_k;

  always_comb begin
    result = operand_x;
    case (func_sel)
      FS_XOR:   result = operand_x ^ operand_y;
      FS_AND:   result = operand_x & operand_y;
      FS_OR:    result = operand_x | operand_y;
      FS_PASSX: result = operand_x;
      default:  result = operand_x;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cjb_logic_unit_arbiter_v.sv
//==============================================================================
// cjb_logic_unit_arbiter_v : two-requester round-robin sequencer for the logic unit
// Revision: 1.0
//==============================================================================
`default_nettype none

module cjb_logic_unit_arbiter_v
  import cjb_logic_unit_arbiter_v_pkg::*;
#(
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Req_A,
  input  logic       Req_B,
  input  logic [1:0] Func_Sel_A,
  input  logic [1:0] Func_Sel_B,
  input  logic [7:0] Operand_X_A,
  input  logic [7:0] Operand_Y_A,
  input  logic [7:0] Operand_X_B,
  input  logic [7:0] Operand_Y_B,
  output logic [1:0] Grant,
  output logic       Ack_A,
  output logic       Ack_B,
  output logic [7:0] Result,
  output logic [3:0] Result_CNVZ,
  output logic       Busy
);

  logic [1:0] state;
  logic [1:0] grant_q;
  logic       last_grant;   // 0 = A, 1 = B
  logic [1:0] fs_q;
  logic [7:0] x_q;
  logic [7:0] y_q;
  logic [7:0] result_q;
  logic [3:0] cnvz_q;
  logic [7:0] lu_result;
  logic       win_b;

  // Contested requests go to whoever did not win last time
  assign win_b = (Req_A && Req_B) ? ~last_grant : Req_B;

  cjb_8bit_logic_unit_v u_logic_unit (
    .func_sel  (fs_q),
    .operand_x (x_q),
    .operand_y (y_q),
    .const_k   (2'b00),
    .result    (lu_result)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= ST_IDLE;
      grant_q    <= 2'b00;
      last_grant <= ~FIRST_GRANT;
      fs_q       <= 2'b00;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      result_q   <= 8'h00;
      cnvz_q     <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req_A || Req_B) begin
            state      <= ST_EXEC;
            grant_q    <= win_b ? 2'b10 : 2'b01;
            last_grant <= win_b;
            fs_q       <= win_b ? Func_Sel_B  : Func_Sel_A;
            x_q        <= win_b ? Operand_X_B : Operand_X_A;
            y_q        <= win_b ? Operand_Y_B : Operand_Y_A;
          end
        end
        ST_EXEC: begin
          result_q <= lu_result;
          cnvz_q   <= cnvz_of(lu_result);
          state    <= ST_DONE;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign Grant       = grant_q;
  assign Ack_A       = (state == ST_DONE) && grant_q[0];
  assign Ack_B       = (state == ST_DONE) && grant_q[1];
  assign Busy        = (state == ST_EXEC) || (state == ST_DONE);
  assign Result      = result_q;
  assign Result_CNVZ = cnvz_q;

endmodule

`default_nettype wire
